// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_pkg
//  Description : Shared types and sizing helpers for the data memory
//                responder and its storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

    // Responder sequencing: accept in IDLE, count down in WAIT, answer in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } data_memory_state_t;

    // Width of the word index for a given storage depth (at least one bit).
    function automatic int dm_index_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    // Width of the latency down-counter; it only ever holds LATENCY-1.
    function automatic int dm_count_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/data_memory_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_array
//  Description : Single-port synchronous word storage. Writes land on the
//                rising edge; reads are registered and only update when
//                re_i is high, so the last read word is held otherwise.
//                Contents are never cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_SIZE   = 32,
    parameter int INDEX_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [INDEX_W-1:0]   index_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    logic [DATA_SIZE-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_SIZE-1:0] rdata_q;

    // Storage write port; no reset so the array maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[index_i] <= wdata_i;
        end
    end

    // Registered read port, cleared on reset so the load bus starts at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[index_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : data_memory_array
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Responder side of the data memory valid/ready interface.
//                Captures a word request, waits a fixed LATENCY, then pulses
//                ready for one cycle with load data or an error flag for
//                out-of-range / misaligned byte addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic                 write_enable,
    input  logic [DATA_SIZE-1:0] write_data,
    input  logic                 valid,
    output logic                 ready,
    output logic [DATA_SIZE-1:0] read_data,
    output logic                 error
);

    localparam int IDX_W = dm_index_width(DEPTH_WORDS);
    localparam int CNT_W = dm_count_width(LATENCY);

    typedef struct packed {
        logic [IDX_W-1:0]     index;
        logic                 write_enable;
        logic [DATA_SIZE-1:0] write_data;
        logic                 bad;
    } data_memory_req_t;

    data_memory_state_t   state_q;
    logic [CNT_W-1:0]     cnt_q;
    data_memory_req_t     req_q;
    logic                 ready_q;
    logic                 error_q;
    logic                 rd_zero_q;

    logic [IDX_W-1:0]     addr_index;
    logic                 addr_misaligned;
    logic                 addr_out_of_range;
    logic                 addr_bad;
    logic                 arr_we;
    logic                 arr_re;
    logic [IDX_W-1:0]     arr_index;
    logic [DATA_SIZE-1:0] arr_rdata;

    // Byte address decode: word index, alignment and range.
    assign addr_index      = addr[IDX_W+1:2];
    assign addr_misaligned = |addr[1:0];

    generate
        if (ADDR_SIZE > IDX_W + 2) begin : g_range_check
            assign addr_out_of_range = |addr[ADDR_SIZE-1:IDX_W+2];
        end else begin : g_no_range_check
            assign addr_out_of_range = 1'b0;
        end
    endgenerate

    assign addr_bad = addr_misaligned | addr_out_of_range;

    // Storage must be read on the edge that enters RESP so the registered
    // load data lines up with ready. With LATENCY = 1 that edge is the
    // acceptance edge itself, so the live address index is used in IDLE.
    assign arr_index = (state_q == IDLE) ? addr_index : req_q.index;
    assign arr_re    = ((LATENCY == 1) && (state_q == IDLE) && valid && !write_enable)
                     || ((state_q == WAIT) && (cnt_q == CNT_W'(1)) && !req_q.write_enable);
    assign arr_we    = (state_q == RESP) && req_q.write_enable && !req_q.bad;

    // Request sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        req_q.index        <= addr_index;
                        req_q.write_enable <= write_enable;
                        req_q.write_data   <= write_data;
                        req_q.bad          <= addr_bad;
                        cnt_q              <= CNT_W'(LATENCY - 1);
                        if (LATENCY > 1) begin
                            state_q <= WAIT;
                        end else begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            error_q <= addr_bad;
                            if (!write_enable) begin
                                rd_zero_q <= addr_bad;
                            end
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        error_q <= req_q.bad;
                        if (!req_q.write_enable) begin
                            rd_zero_q <= req_q.bad;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    data_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_SIZE   (DATA_SIZE),
        .INDEX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .index_i (arr_index),
        .wdata_i (req_q.write_data),
        .rdata_o (arr_rdata)
    );

    // A bad read returns zero; otherwise the array's registered word is shown.
    assign read_data = rd_zero_q ? '0 : arr_rdata;
    assign ready     = ready_q;
    assign error     = error_q;

endmodule : data_memory_responder
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_responder
//  Description : Directed bench for data_memory_responder at LATENCY 1, 2
//                and 4 with hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        valid1, valid2, valid4;
    logic        ready1, ready2, ready4;
    logic        err1, err2, err4;
    logic [31:0] rdata1, rdata2, rdata4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(we), .write_data(wdata),
        .valid(valid1), .ready(ready1), .read_data(rdata1), .error(err1));

    data_memory_responder #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(we), .write_data(wdata),
        .valid(valid2), .ready(ready2), .read_data(rdata2), .error(err2));

    data_memory_responder #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH_WORDS(1024), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(we), .write_data(wdata),
        .valid(valid4), .ready(ready4), .read_data(rdata4), .error(err4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input int sel, input logic v);
        case (sel)
            1:       valid1 = v;
            2:       valid2 = v;
            default: valid4 = v;
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? ready1 : (sel == 2) ? ready2 : ready4;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 1) ? err1 : (sel == 2) ? err2 : err4;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 1) ? rdata1 : (sel == 2) ? rdata2 : rdata4;
    endfunction

    // One request, valid held until ready; returns edges from acceptance to
    // ready (20 on timeout), then checks the pulse has dropped a cycle later.
    task automatic request(input int sel, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic perturb,
                           output int cyc, output logic [31:0] rd, output logic e);
        @(negedge clk);
        addr = a; we = w; wdata = d;
        set_valid(sel, 1'b1);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (perturb && cyc == 1) begin
                addr = 32'h20; we = 1'b1; wdata = 32'h0BAD0BAD;
            end
            if (get_ready(sel)) break;
        end
        rd = get_rdata(sel);
        e  = get_err(sel);
        set_valid(sel, 1'b0);
        we = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", {31'd0, get_ready(sel)}, 32'd0);
        check("error_idle", {31'd0, get_err(sel)}, 32'd0);
    endtask

    // Two reads (0x0 then 0x4) with valid held throughout.
    task automatic back_to_back(input int sel, output int n1, output int n2);
        @(negedge clk);
        addr = 32'h0; we = 1'b0;
        set_valid(sel, 1'b1);
        n1 = 0;
        while (n1 < 20) begin
            @(posedge clk); #1; n1++;
            if (get_ready(sel)) break;
        end
        addr = 32'h4;
        n2 = 0;
        while (n2 < 20) begin
            @(posedge clk); #1; n2++;
            if (get_ready(sel)) break;
        end
        set_valid(sel, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          cyc, n1, n2;
        logic [31:0] rd;
        logic        e;

        rst = 1'b0; addr = '0; we = 1'b0; wdata = '0;
        valid1 = 1'b0; valid2 = 1'b0; valid4 = 1'b0;
        #2;
        check("rst_ready_l1", {31'd0, ready1}, 32'd0);
        check("rst_ready_l2", {31'd0, ready2}, 32'd0);
        check("rst_ready_l4", {31'd0, ready4}, 32'd0);
        check("rst_error_l2", {31'd0, err2}, 32'd0);
        check("rst_rdata_l2", rdata2, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Write then read back at LATENCY 2.
        request(2, 32'h10, 1'b1, 32'hDEADBEEF, 1'b0, cyc, rd, e);
        check("wr10_latency", cyc, 2);
        check("wr10_error", {31'd0, e}, 32'd0);
        request(2, 32'h10, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("rd10_latency", cyc, 2);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_error", {31'd0, e}, 32'd0);

        // Bad addresses must not disturb storage.
        request(2, 32'h0, 1'b1, 32'h12345678, 1'b0, cyc, rd, e);
        check("wr0_error", {31'd0, e}, 32'd0);
        request(2, 32'h1000, 1'b1, 32'hBADBAD00, 1'b0, cyc, rd, e);
        check("wr1000_latency", cyc, 2);
        check("wr1000_error", {31'd0, e}, 32'd1);
        request(2, 32'h2, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("rd2_error", {31'd0, e}, 32'd1);
        check("rd2_data", rd, 32'd0);
        request(2, 32'h0, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("rd0_data", rd, 32'h12345678);
        check("rd0_error", {31'd0, e}, 32'd0);

        // Captured request wins over later input changes.
        request(2, 32'h20, 1'b1, 32'hCAFEF00D, 1'b0, cyc, rd, e);
        request(2, 32'h8, 1'b1, 32'h11111111, 1'b0, cyc, rd, e);
        request(2, 32'h10, 1'b0, 32'h0, 1'b1, cyc, rd, e);
        check("stable_data", rd, 32'hDEADBEEF);
        request(2, 32'h20, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("rd20_data", rd, 32'hCAFEF00D);

        // Asynchronous reset while a write sits in WAIT.
        @(negedge clk);
        addr = 32'h8; we = 1'b1; wdata = 32'h55; valid2 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ready2}, 32'd0);
        check("midrst_error", {31'd0, err2}, 32'd0);
        check("midrst_rdata", rdata2, 32'd0);
        valid2 = 1'b0; we = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle", {31'd0, ready2}, 32'd0);
        request(2, 32'h8, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("postrst_latency", cyc, 2);
        check("postrst_data", rd, 32'h11111111);

        // LATENCY 1.
        request(1, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, cyc, rd, e);
        check("l1_wr_latency", cyc, 1);
        request(1, 32'h0, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("l1_rd_latency", cyc, 1);
        check("l1_rd_data", rd, 32'hA5A5A5A5);
        request(1, 32'h4000, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("l1_bad_error", {31'd0, e}, 32'd1);
        check("l1_bad_data", rd, 32'd0);
        back_to_back(1, n1, n2);
        check("l1_b2b_first", n1, 1);
        check("l1_b2b_interval", n2, 2);

        // LATENCY 4.
        request(4, 32'h4, 1'b1, 32'h0F0F0F0F, 1'b0, cyc, rd, e);
        check("l4_wr_latency", cyc, 4);
        request(4, 32'h4, 1'b0, 32'h0, 1'b0, cyc, rd, e);
        check("l4_rd_latency", cyc, 4);
        check("l4_rd_data", rd, 32'h0F0F0F0F);
        back_to_back(4, n1, n2);
        check("l4_b2b_first", n1, 4);
        check("l4_b2b_interval", n2, 5);
        check("l4_b2b_data", rdata4, 32'h0F0F0F0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_memory_responder
`default_nettype wire

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the data memory interface: the datapath issues word requests; this block services them.
- Single-port word-addressed storage behind a valid/ready handshake, with a configurable fixed access latency.
- Replaces the zero-wait combinational RAM model so the datapath stall path (valid held until ready) can be exercised.
- Sits between the core datapath and on-chip data storage.

Parameters:
- ADDR_SIZE, 32, request address width in bits (byte address).
- DATA_SIZE, 32, data word width in bits.
- DEPTH_WORDS, 1024, number of storage words; power of two, >= 2.
- LATENCY, 2, cycles from request acceptance to ready; >= 1.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- addr  input  ADDR_SIZE  byte address of the request.
- write_enable  input  1  1 = write, 0 = read.
- write_data  input  DATA_SIZE  store data.
- valid  input  1  request present; held until ready.
- ready  output  1  one-cycle completion strobe.
- read_data  output  DATA_SIZE  load data; meaningful only while ready = 1 on a read.
- error  output  1  with ready: request was out of range or misaligned.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, ready = 0, read_data = 0, error = 0, latency counter = 0. Storage contents are not cleared.
- Index decode:
  - word index = addr[$clog2(DEPTH_WORDS)+1:2].
  - Out of range: any addr bit above the index field set.
  - Misaligned: addr[1:0] != 0.
  - Either condition gives bad = 1.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - valid = 1 captures addr, write_enable, write_data and bad into request registers.
    - Counter loads LATENCY-1.
    - Next state is WAIT if LATENCY > 1, else RESP.
    - valid = 0 keeps IDLE.
  - WAIT: counter decrements each cycle. At counter == 1, next state is RESP.
  - RESP (exactly one cycle):
    - ready = 1, error = captured bad.
    - Read, not bad: read_data = storage[captured index].
    - Read, bad: read_data = 0.
    - Write, not bad: storage updated at the end of this cycle.
    - Write, bad: storage unchanged.
    - Next state: IDLE.
- Outputs are registered; ready, read_data and error change only on clk edges.
  - read_data holds its last value outside RESP. The bench must not check it then.
  - error = 0 outside RESP.
- Latency: valid first sampled high at edge k, then ready = 1 during the cycle after edge k+LATENCY-1.
  - LATENCY = 1: ready in the cycle following acceptance.
  - Back-to-back requests: one request per LATENCY+1 cycles (IDLE acceptance cycle, then LATENCY cycles to RESP).
- Changes on addr/write_data/write_enable after acceptance are ignored. The captured request is serviced.
- valid dropping mid-request (protocol violation): the request still completes; ready still pulses.
- Read after write to the same word: the read accepted after the write's RESP returns the new data.
- Reset mid-request (WAIT or RESP): abort, return to IDLE, ready = 0.
  - A write aborted before its RESP edge does not modify storage.
  - A write in RESP when rst asserts may or may not commit; the bench does not check it.

Decomposition:
- Package data_memory_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} data_memory_state_t.
  - Packed struct data_memory_req_t {index, write_enable, write_data, bad}.
  - Localparam helper for index width.
- Sub-module data_memory_array: DEPTH_WORDS x DATA_SIZE single-port synchronous storage (we, index, wdata, rdata registered). The FSM, counter and decode stay in data_memory_responder.

Test Plan:
- Reset: drive rst = 0 mid-run, asynchronously, off-edge -> ready = 0, error = 0, read_data = 0 immediately; FSM in IDLE after release.
- Write then read, LATENCY = 2:
  - Write addr 0x10, data 0xDEADBEEF, valid held -> ready pulses for one cycle, 2 cycles after the acceptance edge.
  - Read 0x10 -> read_data = 0xDEADBEEF with ready, error = 0.
- Latency sweep, LATENCY = 1 and 4: count cycles from acceptance to ready -> exactly 1 and 4. Back-to-back reads of 0x0/0x4 complete every 2 and 5 cycles respectively.
- Bad address, DEPTH_WORDS = 1024:
  - Write to 0x1000 -> ready with error = 1, storage unchanged.
  - Read 0x2 -> error = 1, read_data = 0.
  - Read 0x0 afterwards -> prior contents intact.
- Request stability: change addr to 0x20 one cycle after accepting a read of 0x10 -> response returns the word at 0x10.
- Reset mid-write: write 0x55 to 0x8, assert rst in WAIT, release, then read 0x8 -> old value returned, not 0x55.
